// File: rtl/tea_key_search_engine_if.sv
// Handshake and data bundle between the SOPC wrapper (master) and the
// TEA key-search engine (slave).
interface tea_key_search_engine_if;
  logic         ena;
  logic         start;
  logic         abort;
  logic [31:0]  dataA;
  logic [31:0]  dataB;
  logic [31:0]  magic;
  logic [31:0]  magic_mask;
  logic         busy;
  logic         rdy;
  logic         found;
  logic [31:0]  result;
  logic [127:0] found_key;
  logic [63:0]  plain;

  modport master (
    output ena, start, abort, dataA, dataB, magic, magic_mask,
    input  busy, rdy, found, result, found_key, plain
  );

  modport slave (
    input  ena, start, abort, dataA, dataB, magic, magic_mask,
    output busy, rdy, found, result, found_key, plain
  );
endinterface

// File: rtl/tea_key_search_engine.sv
// Brute-force TEA key search. Each candidate key is a fixed ASCII prefix
// followed by NUM_CHARS characters decoded from a 5-bit-per-char counter.
// Every candidate takes LOAD + 32/UNROLL ROUND + CHECK cycles; the plaintext
// word v0 is compared against a masked magic word. The sweep covers all
// counter values in lower-case mode, then again in upper-case mode.
// Optional macro TEA_SEARCH_RESUME_EN: a start after a hit resumes at the
// candidate following the hit, reusing the latched cipher block.
module tea_key_search_engine #(
  parameter int unsigned  NUM_CHARS = 6,
  parameter int unsigned  UNROLL    = 1,
  parameter logic [127:0] PREFIX_LC = 128'h48756c6b206973207468_000000000000,
  parameter logic [127:0] PREFIX_UC = 128'h48554c4b204953205448_000000000000
) (
  input  logic                    clk,
  input  logic                    rst,
  tea_key_search_engine_if.slave  bus
);

  localparam int unsigned CW        = 5 * NUM_CHARS;
  localparam int unsigned KW        = 8 * NUM_CHARS;
  localparam int unsigned NSTEP     = 32 / UNROLL;
  localparam int unsigned RW        = (CW > 30) ? 30 : CW;
  localparam logic [31:0] DELTA     = 32'h9e3779b9;
  localparam logic [31:0] SUM_INIT  = 32'hc6ef3720;
  localparam logic [5:0]  LAST_STEP = 6'(NSTEP - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_CHECK, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cand_q, cand_d;
  logic           mode_q, mode_d;
  logic           found_q, found_d;
  logic           busy_q, busy_d;
  logic           rdy_q, rdy_d;
  logic [31:0]    ca_q, ca_d;
  logic [31:0]    cb_q, cb_d;
  logic [31:0]    v0_q, v0_d;
  logic [31:0]    v1_q, v1_d;
  logic [31:0]    sum_q, sum_d;
  logic [5:0]     rcnt_q, rcnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   fkey_q, fkey_d;
  logic [63:0]    plain_q, plain_d;
`ifdef TEA_SEARCH_RESUME_EN
  logic           resume_q, resume_d;
`endif

  logic [KW-1:0]  chars;
  logic [127:0]   key_cand;
  logic [31:0]    k0, k1, k2, k3;
  logic [31:0]    v0_rnd, v1_rnd, sum_rnd;
  logic           hit;
  logic [31:0]    result_w;

  // Counter digit -> ASCII: 0..25 are letters (case by mode), 26..31 are '0'..'5'.
  for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_char
    logic [4:0] n;
    assign n = cand_q[5*gi +: 5];
    assign chars[8*gi +: 8] = (n < 5'd26) ? ((mode_q ? 8'h41 : 8'h61) + {3'b000, n})
                                          : (8'h30 + {3'b000, n - 5'd26});
  end

  assign key_cand = {(mode_q ? PREFIX_UC[127:KW] : PREFIX_LC[127:KW]), chars};

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // UNROLL chained decrypt rounds evaluated in one clock.
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_rnd
    logic [31:0] v0_in, v1_in, s_in, v0_out, v1_out, s_out;
    if (gi == 0) begin : g_first
      assign v0_in = v0_q;
      assign v1_in = v1_q;
      assign s_in  = sum_q;
    end else begin : g_next
      assign v0_in = g_rnd[gi-1].v0_out;
      assign v1_in = g_rnd[gi-1].v1_out;
      assign s_in  = g_rnd[gi-1].s_out;
    end
    assign v1_out = v1_in - (((v0_in << 4) + k2) ^ (v0_in + s_in) ^ ((v0_in >> 5) + k3));
    assign v0_out = v0_in - (((v1_out << 4) + k0) ^ (v1_out + s_in) ^ ((v1_out >> 5) + k1));
    assign s_out  = s_in - DELTA;
  end

  assign v0_rnd  = g_rnd[UNROLL-1].v0_out;
  assign v1_rnd  = g_rnd[UNROLL-1].v1_out;
  assign sum_rnd = g_rnd[UNROLL-1].s_out;

  assign hit = (((v0_q ^ bus.magic) & bus.magic_mask) == 32'h0);

  // Status word: mode and found flags on top, current candidate at the bottom.
  always_comb begin
    result_w            = '0;
    result_w[31]        = mode_q;
    result_w[30]        = found_q;
    result_w[RW-1:0]    = cand_q[RW-1:0];
  end

  // Search sequencer: next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    mode_d  = mode_q;
    found_d = found_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    ca_d    = ca_q;
    cb_d    = cb_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    rcnt_d  = rcnt_q;
    key_d   = key_q;
    fkey_d  = fkey_q;
    plain_d = plain_q;
`ifdef TEA_SEARCH_RESUME_EN
    resume_d = resume_q;
`endif
    if ((state_q != S_IDLE) && bus.abort) begin
      // Abort takes priority over any in-flight step, including CHECK.
      state_d = S_IDLE;
      busy_d  = 1'b0;
`ifdef TEA_SEARCH_RESUME_EN
      resume_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_d  = 1'b1;
            found_d = 1'b0;
            fkey_d  = '0;
            plain_d = '0;
            state_d = S_LOAD;
`ifdef TEA_SEARCH_RESUME_EN
            resume_d = 1'b0;
            if (resume_q) begin
              if (mode_q && (&cand_q)) state_d = S_DONE;
              else {mode_d, cand_d} = {mode_q, cand_q} + (CW+1)'(1);
            end else begin
              ca_d   = bus.dataA;
              cb_d   = bus.dataB;
              cand_d = '0;
              mode_d = 1'b0;
            end
`else
            ca_d   = bus.dataA;
            cb_d   = bus.dataB;
            cand_d = '0;
            mode_d = 1'b0;
`endif
          end
`ifdef TEA_SEARCH_RESUME_EN
          else if (bus.abort) begin
            resume_d = 1'b0;
          end
`endif
        end
        S_LOAD: begin
          v0_d    = ca_q;
          v1_d    = cb_q;
          sum_d   = SUM_INIT;
          rcnt_d  = '0;
          key_d   = key_cand;
          state_d = S_ROUND;
        end
        S_ROUND: begin
          v0_d   = v0_rnd;
          v1_d   = v1_rnd;
          sum_d  = sum_rnd;
          rcnt_d = rcnt_q + 6'd1;
          if (rcnt_q == LAST_STEP) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (hit) begin
            found_d = 1'b1;
            fkey_d  = key_q;
            plain_d = {v0_q, v1_q};
            state_d = S_DONE;
`ifdef TEA_SEARCH_RESUME_EN
            resume_d = 1'b1;
`endif
          end else if (!(&cand_q)) begin
            cand_d  = cand_q + CW'(1);
            state_d = S_LOAD;
          end else if (!mode_q) begin
            cand_d  = '0;
            mode_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; ena low freezes everything, including a pending rdy pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      mode_q  <= 1'b0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      rcnt_q  <= '0;
      key_q   <= '0;
      fkey_q  <= '0;
      plain_q <= '0;
`ifdef TEA_SEARCH_RESUME_EN
      resume_q <= 1'b0;
`endif
    end else if (bus.ena) begin
      state_q <= state_d;
      cand_q  <= cand_d;
      mode_q  <= mode_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      rcnt_q  <= rcnt_d;
      key_q   <= key_d;
      fkey_q  <= fkey_d;
      plain_q <= plain_d;
`ifdef TEA_SEARCH_RESUME_EN
      resume_q <= resume_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.rdy       = rdy_q;
  assign bus.found     = found_q;
  assign bus.result    = result_w;
  assign bus.found_key = fkey_q;
  assign bus.plain     = plain_q;

endmodule

// File: tb/tb_tea_key_search_engine.sv
// Directed bench for tea_key_search_engine: three instances
// (2 chars/unroll 1, 1 char/unroll 1, 2 chars/unroll 8) sharing data inputs.
module tb_tea_key_search_engine;

  localparam logic [127:0] PLC   = 128'h48756c6b206973207468_000000000000;
  localparam logic [127:0] PUC   = 128'h48554c4b204953205448_000000000000;
  localparam logic [31:0]  DELTA = 32'h9e3779b9;
  localparam logic [31:0]  PDF   = 32'h25504446;
  localparam logic [31:0]  PT1   = 32'h2d312e34;

  typedef struct {
    string        tag;
    int           lat;
    logic [31:0]  res;
    logic         found;
    logic [127:0] key;
    logic [63:0]  plain;
    logic         chk_plain;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  tea_key_search_engine_if if_a();
  tea_key_search_engine_if if_b();
  tea_key_search_engine_if if_c();

  tea_key_search_engine #(.NUM_CHARS(2), .UNROLL(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  tea_key_search_engine #(.NUM_CHARS(1), .UNROLL(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  tea_key_search_engine #(.NUM_CHARS(2), .UNROLL(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  function automatic logic [127:0] cand_key(input int nch, input logic [39:0] cand, input logic mode);
    logic [127:0] k;
    int nn, c;
    k = mode ? PUC : PLC;
    for (int i = 0; i < nch; i++) begin
      nn = int'(cand[5*i +: 5]);
      c  = (nn < 26) ? ((mode ? 65 : 97) + nn) : (48 + nn - 26);
      k[8*i +: 8] = c[7:0];
    end
    return k;
  endfunction

  function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] pt);
    logic [31:0] v0, v1, s;
    v0 = pt[63:32];
    v1 = pt[31:0];
    s  = 32'h0;
    for (int r = 0; r < 32; r++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic b, output logic r, output logic f,
                         output logic [31:0] res, output logic [127:0] k, output logic [63:0] p);
    case (sel)
      0: begin b = if_a.busy; r = if_a.rdy; f = if_a.found; res = if_a.result; k = if_a.found_key; p = if_a.plain; end
      1: begin b = if_b.busy; r = if_b.rdy; f = if_b.found; res = if_b.result; k = if_b.found_key; p = if_b.plain; end
      default: begin b = if_c.busy; r = if_c.rdy; f = if_c.found; res = if_c.result; k = if_c.found_key; p = if_c.plain; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: if_a.start = v;
      1: if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  task automatic ena_all(input logic v);
    if_a.ena = v; if_b.ena = v; if_c.ena = v;
  endtask

  task automatic abort_all(input logic v);
    if_a.abort = v; if_b.abort = v; if_c.abort = v;
  endtask

  task automatic set_data(input logic [63:0] ct, input logic [31:0] m, input logic [31:0] mk);
    if_a.dataA = ct[63:32]; if_b.dataA = ct[63:32]; if_c.dataA = ct[63:32];
    if_a.dataB = ct[31:0];  if_b.dataB = ct[31:0];  if_c.dataB = ct[31:0];
    if_a.magic = m;  if_b.magic = m;  if_c.magic = m;
    if_a.magic_mask = mk; if_b.magic_mask = mk; if_c.magic_mask = mk;
  endtask

  task automatic push_exp(input string tag, input int lat, input logic [31:0] res, input logic f,
                          input logic [127:0] k, input logic [63:0] p, input logic cp);
    exp_t e;
    e.tag = tag; e.lat = lat; e.res = res; e.found = f; e.key = k; e.plain = p; e.chk_plain = cp;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; the edge that samples it is edge 0 of the search.
  task automatic start_search(input int sel);
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  // Wait (bounded) for rdy, optionally stalling via ena or poking start while busy,
  // then compare against the oldest scoreboard entry.
  task automatic run_expect(input int sel, input int stall_at, input int poke_at);
    exp_t e;
    int n;
    logic seen, b, r, f;
    logic [31:0] res;
    logic [127:0] k;
    logic [63:0] p;
    e = sb.pop_front();
    seen = 1'b0;
    n = 0;
    while (!seen && n < e.lat + 300) begin
      @(posedge clk); #1;
      n++;
      if (stall_at > 0 && n == stall_at) ena_all(1'b0);
      if (stall_at > 0 && n == stall_at + 100) ena_all(1'b1);
      if (poke_at > 0 && n == poke_at) set_start(sel, 1'b1);
      if (poke_at > 0 && n == poke_at + 1) begin
        set_start(sel, 1'b0);
        get_out(sel, b, r, f, res, k, p);
        chk({e.tag, " busy_mid"}, b, 1'b1);
      end
      get_out(sel, b, r, f, res, k, p);
      if (r) seen = 1'b1;
    end
    chk({e.tag, " rdy_seen"}, seen, 1'b1);
    if (seen) begin
      $display("[%0t] %s: latency=%0d result=%h found=%b key=%h plain=%h",
               $time, e.tag, n, res, f, k, p);
      chk({e.tag, " latency"}, n, e.lat);
      chk({e.tag, " result"}, res, e.res);
      chk({e.tag, " found"}, f, e.found);
      chk({e.tag, " found_key"}, k, e.key);
      if (e.chk_plain) chk({e.tag, " plain"}, p, e.plain);
      chk({e.tag, " busy_end"}, b, 1'b0);
      @(posedge clk); #1;
      get_out(sel, b, r, f, res, k, p);
      chk({e.tag, " rdy_one_cycle"}, r, 1'b0);
    end
  endtask

  initial begin
    logic b, r, f, any_rdy;
    logic [31:0] res;
    logic [127:0] k, k_m0, k_m1, k_b0;
    logic [63:0] p, ct_m0, ct_m1, ct_nh, pt_b, ct_b;

    ena_all(1'b1);
    abort_all(1'b0);
    set_start(0, 1'b0); set_start(1, 1'b0); set_start(2, 1'b0);
    set_data(64'h0, 32'h0, 32'h0);

    k_m0  = cand_key(2, 40'h123, 1'b0);
    ct_m0 = tea_enc(k_m0, {PDF, PT1});
    k_m1  = cand_key(2, 40'h005, 1'b1);
    ct_m1 = tea_enc(k_m1, {PDF, PT1});

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    get_out(0, b, r, f, res, k, p);
    chk("reset busy", b, 1'b0);
    chk("reset rdy", r, 1'b0);
    chk("reset found", f, 1'b0);
    chk("reset result", res, 32'h0);
    chk("reset found_key", k, 128'h0);
    chk("reset plain", p, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Mode-0 hit, with a start pulse while busy that must be ignored
    set_data(ct_m0, PDF, 32'hffffffff);
    push_exp("hit_m0_u1", 292*34+1, 32'h4000_0123, 1'b1, k_m0, {PDF, PT1}, 1'b1);
    start_search(0);
    run_expect(0, 0, 100);

    // Same hit with 8 rounds per clock
    push_exp("hit_m0_u8", 292*6+1, 32'h4000_0123, 1'b1, k_m0, {PDF, PT1}, 1'b1);
    start_search(2);
    run_expect(2, 0, 0);

    // Asynchronous reset in the middle of ROUND
    start_search(0);
    for (int i = 0; i < 34*3+10; i++) begin
      @(posedge clk); #1;
    end
    get_out(0, b, r, f, res, k, p);
    chk("pre_reset busy", b, 1'b1);
`ifdef TEA_SEARCH_RESUME_EN
    chk("pre_reset result", res, 32'h0000_0127);
`else
    chk("pre_reset result", res, 32'h0000_0003);
`endif
    rst = 1'b0;
    #1;
    get_out(0, b, r, f, res, k, p);
    chk("mid_reset busy", b, 1'b0);
    chk("mid_reset result", res, 32'h0);
    get_out(2, b, r, f, res, k, p);
    chk("mid_reset other found", f, 1'b0);
    chk("mid_reset other result", res, 32'h0);
    chk("mid_reset other found_key", k, 128'h0);
    chk("mid_reset other plain", p, 64'h0);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    get_out(0, b, r, f, res, k, p);
    chk("start_in_reset busy", b, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Mode-1 hit
    set_data(ct_m1, PDF, 32'hffffffff);
    push_exp("hit_m1_u1", (1024+5+1)*34+1, 32'hC000_0005, 1'b1, k_m1, {PDF, PT1}, 1'b1);
    start_search(0);
    run_expect(0, 0, 0);

    // Exhaustive sweep with no hit, one generated character
    ct_nh = {$urandom, $urandom};
    set_data(ct_nh, PDF, 32'hffffffff);
    push_exp("no_hit_n1", 64*34+1, 32'h8000_001F, 1'b0, 128'h0, 64'h0, 1'b1);
    start_search(1);
    run_expect(1, 0, 0);

    // ena held low for 100 cycles mid-search
    set_data(ct_m0, PDF, 32'hffffffff);
    push_exp("stall_u8", 292*6+1+100, 32'h4000_0123, 1'b1, k_m0, {PDF, PT1}, 1'b1);
    start_search(2);
    run_expect(2, 500, 0);

    // Abort mid-search: busy drops next cycle and no rdy follows
    start_search(2);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
    end
    abort_all(1'b1);
    @(posedge clk); #1;
    abort_all(1'b0);
    get_out(2, b, r, f, res, k, p);
    chk("abort busy", b, 1'b0);
    chk("abort found", f, 1'b0);
    any_rdy = 1'b0;
    for (int i = 0; i < 1900; i++) begin
      @(posedge clk); #1;
      get_out(2, b, r, f, res, k, p);
      if (r) any_rdy = 1'b1;
    end
    chk("abort no_rdy", any_rdy, 1'b0);
    $display("[%0t] abort_u8: rdy_after_abort=%b busy=%b", $time, any_rdy, b);

    // Start and abort together in IDLE: start wins
    @(posedge clk); #1;
    abort_all(1'b1);
    set_start(2, 1'b1);
    @(posedge clk); #1;
    abort_all(1'b0);
    set_start(2, 1'b0);
    get_out(2, b, r, f, res, k, p);
    chk("start_beats_abort busy", b, 1'b1);
    abort_all(1'b1);
    @(posedge clk); #1;
    abort_all(1'b0);
    get_out(2, b, r, f, res, k, p);
    chk("abort_after_start busy", b, 1'b0);
    $display("[%0t] start_abort_same_cycle: busy_after_second_abort=%b", $time, b);

    // magic_mask = 0: candidate 0 of mode 0 hits at once
    k_b0 = cand_key(1, 40'h0, 1'b0);
    pt_b = {$urandom, $urandom};
    ct_b = tea_enc(k_b0, pt_b);
    set_data(ct_b, 32'h1234_5678, 32'h0);
    push_exp("mask0_first", 34+1, 32'h4000_0000, 1'b1, k_b0, pt_b, 1'b1);
    start_search(1);
    run_expect(1, 0, 0);
`ifdef TEA_SEARCH_RESUME_EN
    push_exp("mask0_resume", 34+1, 32'h4000_0001, 1'b1, cand_key(1, 40'h1, 1'b0), 64'h0, 1'b0);
`else
    push_exp("mask0_restart", 34+1, 32'h4000_0000, 1'b1, k_b0, pt_b, 1'b1);
`endif
    start_search(1);
    run_expect(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
